// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: access sizes, FSM states,
// winner encoding and the address alignment rule.
package mem_arbiter_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } mem_access_size_t;

   typedef enum logic [2:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      ERR_I,
      ERR_D
   } mem_arb_state_t;

   typedef enum logic [1:0] {
      WIN_NONE,
      WIN_I,
      WIN_D
   } mem_arb_winner_t;

   function automatic logic mem_addr_aligned(input logic [1:0] addr_lo, input mem_access_size_t size);
      logic ok;
      case (size)
         SIZE_BYTE: ok = 1'b1;
         SIZE_HALF: ok = ~addr_lo[0];
         SIZE_WORD: ok = (addr_lo == 2'b00);
         default:   ok = 1'b0; // encoding 3 is rejected like a misaligned access
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and downstream-memory signals of the arbiter; slave = arbiter side,
// master = the surrounding requesters and memory.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   import mem_arbiter_pkg::*;

   logic              ireq_i;
   logic [ADDR_W-1:0] iaddr_i;
   logic              idone_o;
   logic [31:0]       irdata_o;
   logic              ierr_o;

   logic              dreq_i;
   logic [ADDR_W-1:0] daddr_i;
   mem_access_size_t  dsize_i;
   logic              dwe_i;
   logic [31:0]       dwdata_i;
   logic              ddone_o;
   logic [31:0]       drdata_o;
   logic              derr_o;

   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   mem_access_size_t  mem_size_o;
   logic              mem_we_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_ack_i;
   logic [31:0]       mem_rdata_i;

   modport slave (
      input  ireq_i, iaddr_i, dreq_i, daddr_i, dsize_i, dwe_i, dwdata_i,
             mem_ack_i, mem_rdata_i,
      output idone_o, irdata_o, ierr_o, ddone_o, drdata_o, derr_o,
             mem_req_o, mem_addr_o, mem_size_o, mem_we_o, mem_wdata_o
   );

   modport master (
      output ireq_i, iaddr_i, dreq_i, daddr_i, dsize_i, dwe_i, dwdata_i,
             mem_ack_i, mem_rdata_i,
      input  idone_o, irdata_o, ierr_o, ddone_o, drdata_o, derr_o,
             mem_req_o, mem_addr_o, mem_size_o, mem_we_o, mem_wdata_o
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Priority policy: data first, except fetch wins once it has been passed over
// STARVE_LIMIT consecutive times.
module mem_arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic             ireq,
   input  logic             dreq,
   input  logic [CNT_W-1:0] starve_cnt,
   output mem_arb_winner_t  winner
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   always_comb begin
      winner = WIN_NONE;
      if (ireq && dreq && (starve_cnt == LIMIT)) begin
         winner = WIN_I;
      end else if (dreq) begin
         winner = WIN_D;
      end else if (ireq) begin
         winner = WIN_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto one single-ported memory, rejecting
// misaligned accesses locally.
//
// state  | meaning
// IDLE   | no transaction; picks a winner from the pending requests
// BUSY_I | fetch in flight downstream, waiting for mem_ack_i
// BUSY_D | data access in flight downstream, waiting for mem_ack_i
// ERR_I  | misaligned fetch, one-cycle error completion
// ERR_D  | misaligned or bad-size data access, one-cycle error completion
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic           clk_i,
   input  logic           reset_ni,
   mem_arbiter_if.slave   bus
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   mem_arb_state_t    state_q, state_d;
   mem_arb_winner_t   winner;
   logic [CNT_W-1:0]  starve_cnt;
   logic              i_aligned, d_aligned;

   logic [ADDR_W-1:0] mem_addr_q;
   mem_access_size_t  mem_size_q;
   logic              mem_we_q;
   logic [31:0]       mem_wdata_q;

   logic              mem_req, idone, ierr, ddone, derr;
   logic [31:0]       irdata, drdata;

   assign i_aligned = mem_addr_aligned(bus.iaddr_i[1:0], SIZE_WORD);
   assign d_aligned = mem_addr_aligned(bus.daddr_i[1:0], bus.dsize_i);

   mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
      .ireq       (bus.ireq_i),
      .dreq       (bus.dreq_i),
      .starve_cnt (starve_cnt),
      .winner     (winner)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (winner == WIN_I)      state_d = i_aligned ? BUSY_I : ERR_I;
            else if (winner == WIN_D) state_d = d_aligned ? BUSY_D : ERR_D;
         end
         BUSY_I, BUSY_D: if (bus.mem_ack_i) state_d = IDLE;
         ERR_I, ERR_D:   state_d = IDLE;
         default:        state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req = 1'b0;
      idone   = 1'b0;
      ierr    = 1'b0;
      irdata  = '0;
      ddone   = 1'b0;
      derr    = 1'b0;
      drdata  = '0;
      case (state_q)
         BUSY_I: begin
            mem_req = 1'b1;
            idone   = bus.mem_ack_i;
            irdata  = bus.mem_ack_i ? bus.mem_rdata_i : '0;
         end
         BUSY_D: begin
            mem_req = 1'b1;
            ddone   = bus.mem_ack_i;
            drdata  = bus.mem_ack_i ? bus.mem_rdata_i : '0;
         end
         ERR_I: begin
            idone = 1'b1;
            ierr  = 1'b1;
         end
         ERR_D: begin
            ddone = 1'b1;
            derr  = 1'b1;
         end
         default: ;
      endcase
   end

   // Downstream registers only load on an aligned grant; errors leave them untouched.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         mem_addr_q  <= '0;
         mem_size_q  <= SIZE_BYTE;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else if (state_q == IDLE) begin
         if (winner == WIN_I && i_aligned) begin
            mem_addr_q  <= bus.iaddr_i;
            mem_size_q  <= SIZE_WORD;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
         end else if (winner == WIN_D && d_aligned) begin
            mem_addr_q  <= bus.daddr_i;
            mem_size_q  <= bus.dsize_i;
            mem_we_q    <= bus.dwe_i;
            mem_wdata_q <= bus.dwdata_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         starve_cnt <= '0;
      end else if (state_q == IDLE && winner != WIN_NONE) begin
         if (winner == WIN_D && bus.ireq_i)
            starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
         else
            starve_cnt <= '0;
      end
   end

   assign bus.mem_req_o   = mem_req;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_size_o  = mem_size_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.idone_o     = idone;
   assign bus.irdata_o    = irdata;
   assign bus.ierr_o      = ierr;
   assign bus.ddone_o     = ddone;
   assign bus.drdata_o    = drdata;
   assign bus.derr_o      = derr;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported unified memory between the pipeline's instruction-fetch requester (IF stage) and data requester (MEM stage). It serialises requests with an FSM and prioritises data, which is the older instruction, while a bounded-wait rule prevents fetch starvation. Misaligned accesses are rejected locally without reaching memory. It sits between the datapath's two memory interfaces and the memory model or bus.

Parameters:
STARVE_LIMIT, 4, consecutive data grants tolerated while a fetch is pending before fetch is forced; legal range 1..15
ADDR_W, 32, address width

Ports:
clk_i  in  1  clock, rising edge
reset_ni  in  1  asynchronous, active-low reset
ireq_i  in  1  fetch request; held with iaddr_i stable until idone_o
iaddr_i  in  ADDR_W  fetch address; size is always word
idone_o  out  1  fetch complete (1-cycle pulse)
irdata_o  out  32  fetch data, valid only with idone_o
ierr_o  out  1  misaligned fetch, valid only with idone_o
dreq_i  in  1  data request; held with all d* inputs stable until ddone_o
daddr_i  in  ADDR_W  data address
dsize_i  in  2  mem_access_size_t (byte/half/word)
dwe_i  in  1  1 = store, 0 = load
dwdata_i  in  32  store data
ddone_o  out  1  data complete (1-cycle pulse)
drdata_o  out  32  load data, valid only with ddone_o
derr_o  out  1  misaligned data access, valid only with ddone_o
mem_req_o  out  1  downstream request, held until mem_ack_i
mem_addr_o  out  ADDR_W  registered address
mem_size_o  out  2  registered size
mem_we_o  out  1  registered write enable
mem_wdata_o  out  32  registered store data
mem_ack_i  in  1  downstream completion; sampled only while mem_req_o = 1
mem_rdata_i  in  32  downstream read data, valid with mem_ack_i

Behaviour:
- Reset (async, reset_ni = 0):
  - FSM goes to IDLE and starve_cnt to 0.
  - All registered outputs go to 0 immediately, including mem_req_o.
  - An in-flight downstream transaction is abandoned; downstream must tolerate this.
- FSM states:
  - IDLE, BUSY_I, BUSY_D: mem_req_o = 1 exactly in the two BUSY states.
  - ERR_I, ERR_D: one cycle each, no downstream request.
- IDLE, winner selection:
  - If both requesters assert and starve_cnt == STARVE_LIMIT, the winner is I.
  - Otherwise data wins whenever dreq_i = 1, and I wins when only ireq_i = 1.
  - No request: stay in IDLE.
- IDLE, alignment check on the winner:
  - Half access requires addr[0] = 0; word access requires addr[1:0] = 0; byte is always aligned.
  - Misaligned: go to ERR_x, mem_* unchanged.
  - Aligned: latch addr/size/we/wdata into the mem_* registers and go to BUSY_x. Fetch uses size WORD and we = 0.
  - Latency: request sampled at edge N, mem_req_o high from cycle N+1.
- BUSY_x:
  - Hold mem_* stable until mem_ack_i = 1.
  - In the ack cycle, x_done_o = 1 (combinational from mem_ack_i), x_rdata_o = mem_rdata_i and x_err_o = 0. The next state is IDLE.
  - Stores also pulse ddone_o; drdata_o is don't-care for stores.
- ERR_x: x_done_o = 1, x_err_o = 1, x_rdata_o = 0; next state is IDLE.
- Done pulses: the non-winning done_o is never asserted, and idone_o and ddone_o are never high in the same cycle.
- Requester obligations: a requester deasserts or changes its request in the cycle after its done pulse. Because the FSM is in IDLE that cycle, a stale request is never re-granted.
- starve_cnt update, at each grant from IDLE, including error grants:
  - D granted while ireq_i = 1: increment, saturating at STARVE_LIMIT.
  - I granted, or D granted with ireq_i = 0: clear to 0.
- Throughput: at most one transaction per 2 cycles (BUSY followed by IDLE) with a zero-wait memory.
- Unknown dsize_i encoding (value 3): treated as misaligned, giving ERR_D.

Decomposition:
- Package definitions holds:
  - mem_access_size_t (shared with the datapath).
  - new enum mem_arb_state_t {IDLE, BUSY_I, BUSY_D, ERR_I, ERR_D}.
  - function mem_addr_aligned(addr, size).
- One combinational sub-module, mem_arb_pick: inputs ireq/dreq/starve_cnt/STARVE_LIMIT, output winner. It is kept separate so the priority policy can be unit-tested on its own.

Test Plan:
- Reset: assert reset_ni = 0 mid-BUSY_D with mem_req_o = 1 -> mem_req_o drops to 0 without waiting for a clock edge; after release, a fetch to 0x00010000 completes normally.
- Single fetch: ireq_i with iaddr 0x00010000, memory acks 2 cycles after mem_req_o and returns 0x00000013 -> mem_req_o rises one cycle after the request, mem_size_o = WORD, idone_o pulses in the ack cycle with irdata_o = 0x00000013, ierr_o = 0.
- Simultaneous: ireq_i and dreq_i (load word 0x2000) asserted in the same cycle -> data is served first; fetch is granted in the IDLE cycle after ddone_o.
- Starvation: STARVE_LIMIT = 4, ireq_i held high, dreq_i re-asserted immediately after each ddone_o -> exactly 4 data grants, then a fetch grant; starve_cnt returns to 0.
- Misaligned: store half to 0x2001 -> ERR_D one cycle after the request, ddone_o = 1, derr_o = 1, mem_req_o stays 0; fetch to 0x00010002 gives ierr_o = 1.
- Store byte 0xA5 to 0x2003 -> mem_we_o = 1, mem_size_o = BYTE, mem_wdata_o = 0x000000A5, all held stable across 3 wait cycles until ack, then ddone_o pulses.
